// File: rtl/intr_ctrl85.sv
// ---------------------------------------------------------------------------
// intr_ctrl85 -- 8085-style interrupt controller
//
// Synchronizes the five interrupt pins and SID, keeps the TRAP and RST7.5
// edge latches, the SIM masks, the EI/DI enable and the SOD latch.
// Arbitrates by fixed priority (TRAP > 7.5 > 6.5 > 5.5 > INTR) and runs
// either a one-cycle restart vector or an INTA bus sequence.
//
// Ports
//   CLK, RST                      clock, synchronous active-high reset
//   TRAP, RST75, RST65, RST55,
//   INTR, SID                     asynchronous pins
//   sim_wr, sim_data[7:0]         SIM strobe and accumulator value
//   ie_set, ie_clr                EI / DI strobes
//   instr_done, int_ack           instruction boundary, core accepts
//   bus_done, op_call             INTA cycle complete, INTA1 byte is CALL
//   int_req                       registered request to control unit
//   vec_valid, int_vec            one-cycle restart address pulse
//   inta_req, int_src[2:0]        INTA cycle request, accepted source
//   rim_data[7:0], sod            RIM value, serial output latch
// ---------------------------------------------------------------------------
module intr_ctrl85 #(
  parameter int VEC_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 TRAP,
  input  logic                 RST75,
  input  logic                 RST65,
  input  logic                 RST55,
  input  logic                 INTR,
  input  logic                 SID,
  input  logic                 sim_wr,
  input  logic [7:0]           sim_data,
  input  logic                 ie_set,
  input  logic                 ie_clr,
  input  logic                 instr_done,
  input  logic                 int_ack,
  input  logic                 bus_done,
  input  logic                 op_call,
  output logic                 int_req,
  output logic                 vec_valid,
  output logic [VEC_WIDTH-1:0] int_vec,
  output logic                 inta_req,
  output logic [2:0]           int_src,
  output logic [7:0]           rim_data,
  output logic                 sod
);

  typedef enum logic [2:0] {S_IDLE, S_VEC, S_INTA1, S_INTA2, S_INTA3} state_e;

  // Bit positions inside the synchronizer vectors.
  localparam int P_TRAP = 0;
  localparam int P_R75  = 1;
  localparam int P_R65  = 2;
  localparam int P_R55  = 3;
  localparam int P_INTR = 4;
  localparam int P_SID  = 5;

  state_e                 state_q, state_d;
  logic [5:0]             sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]             prev_q, prev_d;      // delayed sync of TRAP / RST7.5
  logic                   trap_l_q, trap_l_d;
  logic                   i75_q, i75_d;
  logic                   ie_q, ie_d, ie_pend_q, ie_pend_d;
  logic [2:0]             mask_q, mask_d;      // {M7.5, M6.5, M5.5}
  logic                   sod_q, sod_d;
  logic                   int_req_q, int_req_d;
  logic                   vec_valid_q, vec_valid_d;
  logic [VEC_WIDTH-1:0]   int_vec_q, int_vec_d;
  logic [2:0]             int_src_q, int_src_d;

  logic [1:0]             rise;
  logic [4:0]             elig;
  logic                   any_elig, accept;
  logic [2:0]             sel_src;
  logic [7:0]             sel_vec;
  logic                   sim_unused;

  assign sim_unused = sim_data[5];

  // Rising edges are taken straight from the synchronizer so the request
  // can assert in the same cycle the edge is first seen; the latches only
  // remember the edge for later.
  assign rise = sync2_q[P_R75:P_TRAP] & ~prev_q;

  assign elig[0] = (trap_l_q | rise[0]) & sync2_q[P_TRAP];
  assign elig[1] = (i75_q | rise[1]) & ie_q & ~mask_q[2];
  assign elig[2] = sync2_q[P_R65] & ie_q & ~mask_q[1];
  assign elig[3] = sync2_q[P_R55] & ie_q & ~mask_q[0];
  assign elig[4] = sync2_q[P_INTR] & ie_q;
  assign any_elig = |elig;

  // Acceptance also requires a live eligible source: if the level that
  // raised int_req has already gone away the ack is dropped.
  assign accept = (state_q == S_IDLE) & int_ack & instr_done & int_req_q & any_elig;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    sel_src = 3'd4;
    sel_vec = 8'h00;
    if (elig[0]) begin
      sel_src = 3'd0; sel_vec = 8'h24;
    end else if (elig[1]) begin
      sel_src = 3'd1; sel_vec = 8'h3C;
    end else if (elig[2]) begin
      sel_src = 3'd2; sel_vec = 8'h34;
    end else if (elig[3]) begin
      sel_src = 3'd3; sel_vec = 8'h2C;
    end
  end

  always_comb begin
    sync1_d     = {SID, INTR, RST55, RST65, RST75, TRAP};
    sync2_d     = sync1_q;
    prev_d      = sync2_q[P_R75:P_TRAP];
    state_d     = state_q;
    trap_l_d    = trap_l_q;
    i75_d       = i75_q;
    ie_d        = ie_q;
    ie_pend_d   = ie_pend_q;
    mask_d      = mask_q;
    sod_d       = sod_q;
    vec_valid_d = 1'b0;
    int_vec_d   = int_vec_q;
    int_src_d   = int_src_q;
    int_req_d   = (state_q == S_IDLE) & any_elig & ~accept;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          int_src_d = sel_src;
          if (sel_src == 3'd4) begin
            state_d = S_INTA1;
          end else begin
            state_d     = S_VEC;
            vec_valid_d = 1'b1;
            int_vec_d   = VEC_WIDTH'(sel_vec);
          end
        end
      end
      S_VEC:   state_d = S_IDLE;
      S_INTA1: if (bus_done) state_d = op_call ? S_INTA2 : S_IDLE;
      S_INTA2: if (bus_done) state_d = S_INTA3;
      S_INTA3: if (bus_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A fresh edge always wins over any clear in the same cycle.
    if (rise[0])                        trap_l_d = 1'b1;
    else if (accept && sel_src == 3'd0) trap_l_d = 1'b0;

    if (rise[1])                                               i75_d = 1'b1;
    else if ((accept && sel_src == 3'd1) || (sim_wr && sim_data[4])) i75_d = 1'b0;

    // EI takes effect one instruction late; DI and acceptance are immediate.
    if (ie_clr || accept) begin
      ie_d      = 1'b0;
      ie_pend_d = 1'b0;
    end else if (ie_set) begin
      ie_pend_d = 1'b1;
    end else if (instr_done && ie_pend_q) begin
      ie_d      = 1'b1;
      ie_pend_d = 1'b0;
    end

    if (sim_wr && sim_data[3]) mask_d = sim_data[2:0];
    if (sim_wr && sim_data[6]) sod_d  = sim_data[7];
  end

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (RST) begin
      state_q     <= S_IDLE;
      sync1_q     <= '0;
      sync2_q     <= '0;
      prev_q      <= '0;
      trap_l_q    <= 1'b0;
      i75_q       <= 1'b0;
      ie_q        <= 1'b0;
      ie_pend_q   <= 1'b0;
      mask_q      <= 3'b111;
      sod_q       <= 1'b0;
      int_req_q   <= 1'b0;
      vec_valid_q <= 1'b0;
      int_vec_q   <= '0;
      int_src_q   <= 3'd0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      trap_l_q    <= trap_l_d;
      i75_q       <= i75_d;
      ie_q        <= ie_d;
      ie_pend_q   <= ie_pend_d;
      mask_q      <= mask_d;
      sod_q       <= sod_d;
      int_req_q   <= int_req_d;
      vec_valid_q <= vec_valid_d;
      int_vec_q   <= int_vec_d;
      int_src_q   <= int_src_d;
    end
  end

  assign int_req   = int_req_q;
  assign vec_valid = vec_valid_q;
  assign int_vec   = int_vec_q;
  assign int_src   = int_src_q;
  assign sod       = sod_q;
  assign inta_req  = (state_q == S_INTA1) | (state_q == S_INTA2) | (state_q == S_INTA3);
  assign rim_data  = {sync2_q[P_SID], i75_q, sync2_q[P_R65], sync2_q[P_R55],
                      ie_q, mask_q};

endmodule

// File: tb/tb_intr_ctrl85.sv
// ---------------------------------------------------------------------------
// tb_intr_ctrl85 -- self-checking bench for intr_ctrl85
// SIM table vectors, directed multi-cycle scenarios, then random stimulus
// compared every cycle against a pin-history reference model.
// ---------------------------------------------------------------------------
module tb_intr_ctrl85;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        TRAP = 0, RST75 = 0, RST65 = 0, RST55 = 0, INTR = 0, SID = 0;
  logic        sim_wr = 0;
  logic [7:0]  sim_data = '0;
  logic        ie_set = 0, ie_clr = 0, instr_done = 0, int_ack = 0;
  logic        bus_done = 0, op_call = 0;
  logic        int_req, vec_valid, inta_req, sod;
  logic [15:0] int_vec;
  logic [2:0]  int_src;
  logic [7:0]  rim_data;

  int n_checks = 0;
  int n_fail   = 0;

  intr_ctrl85 #(.VEC_WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .TRAP(TRAP), .RST75(RST75), .RST65(RST65),
    .RST55(RST55), .INTR(INTR), .SID(SID), .sim_wr(sim_wr), .sim_data(sim_data),
    .ie_set(ie_set), .ie_clr(ie_clr), .instr_done(instr_done), .int_ack(int_ack),
    .bus_done(bus_done), .op_call(op_call), .int_req(int_req),
    .vec_valid(vec_valid), .int_vec(int_vec), .inta_req(inta_req),
    .int_src(int_src), .rim_data(rim_data), .sod(sod)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobes_off();
    sim_wr = 0; ie_set = 0; ie_clr = 0; instr_done = 0; int_ack = 0; bus_done = 0;
  endtask

  task automatic sim_write(input logic [7:0] d);
    sim_wr = 1; sim_data = d; tick(); sim_wr = 0;
  endtask

  task automatic enable_ints();
    ie_set = 1; tick(); ie_set = 0;
    instr_done = 1; tick(); instr_done = 0;
  endtask

  task automatic ack();
    instr_done = 1; int_ack = 1; tick(); instr_done = 0; int_ack = 0;
  endtask

  // ---------------- SIM table ----------------
  typedef struct {
    logic [7:0] data;
    logic [2:0] exp_mask;
    logic       exp_sod;
  } sim_vec_t;

  // ---------------- reference model ----------------
  // Pin history per pin: h[p][0] = sampled at the latest edge, [1] one
  // edge earlier (what the core sees as synchronized), [2] two earlier.
  logic        h [6][3];
  logic        m_trap_l, m_i75, m_ie, m_pend, m_sod, m_int_req, m_vec_valid;
  logic [2:0]  m_mask, m_src;
  logic [15:0] m_vec;
  int          m_mode;   // 0 idle, 1 vector, 2..4 INTA cycle number

  function automatic logic [15:0] vec_of(input int src);
    case (src)
      0: return 16'h0024;
      1: return 16'h003C;
      2: return 16'h0034;
      default: return 16'h002C;
    endcase
  endfunction

  task automatic model_edge();
    logic pins [6];
    logic req [5];
    logic sy [6];
    logic ed [6];
    int   win;
    logic acc;
    pins[0] = TRAP; pins[1] = RST75; pins[2] = RST65;
    pins[3] = RST55; pins[4] = INTR; pins[5] = SID;
    if (RST) begin
      for (int p = 0; p < 6; p++) for (int j = 0; j < 3; j++) h[p][j] = 0;
      m_trap_l = 0; m_i75 = 0; m_ie = 0; m_pend = 0; m_sod = 0;
      m_int_req = 0; m_vec_valid = 0; m_mask = 3'b111; m_src = 0; m_vec = 0;
      m_mode = 0;
      return;
    end
    for (int p = 0; p < 6; p++) begin
      sy[p] = h[p][1];
      ed[p] = h[p][1] & ~h[p][2];
    end
    req[0] = (m_trap_l | ed[0]) & sy[0];
    req[1] = (m_i75 | ed[1]) & m_ie & ~m_mask[2];
    req[2] = sy[2] & m_ie & ~m_mask[1];
    req[3] = sy[3] & m_ie & ~m_mask[0];
    req[4] = sy[4] & m_ie;
    win = -1;
    for (int s = 4; s >= 0; s--) if (req[s]) win = s;
    acc = (m_mode == 0) && int_ack && instr_done && m_int_req && (win >= 0);

    m_int_req   = (m_mode == 0) && !acc && (win >= 0);
    m_vec_valid = acc && (win < 4);
    if (acc) begin
      m_src = 3'(win);
      if (win < 4) begin m_vec = vec_of(win); m_mode = 1; end
      else m_mode = 2;
    end else begin
      case (m_mode)
        1: m_mode = 0;
        2: if (bus_done) m_mode = op_call ? 3 : 0;
        3: if (bus_done) m_mode = 4;
        4: if (bus_done) m_mode = 0;
        default: ;
      endcase
    end
    if (ed[0]) m_trap_l = 1;
    else if (acc && win == 0) m_trap_l = 0;
    if (ed[1]) m_i75 = 1;
    else if ((acc && win == 1) || (sim_wr && sim_data[4])) m_i75 = 0;
    if (ie_clr || acc) begin m_ie = 0; m_pend = 0; end
    else if (ie_set) m_pend = 1;
    else if (instr_done && m_pend) begin m_ie = 1; m_pend = 0; end
    if (sim_wr && sim_data[3]) m_mask = sim_data[2:0];
    if (sim_wr && sim_data[6]) m_sod = sim_data[7];
    for (int p = 0; p < 6; p++) begin
      h[p][2] = h[p][1]; h[p][1] = h[p][0]; h[p][0] = pins[p];
    end
  endtask

  initial begin
    sim_vec_t tab [7];
    logic [7:0] exp_rim;
    tab[0] = '{8'h08, 3'b000, 1'b0};
    tab[1] = '{8'h0D, 3'b101, 1'b0};
    tab[2] = '{8'h05, 3'b101, 1'b0};   // mask enable clear: masks held
    tab[3] = '{8'hC0, 3'b101, 1'b1};
    tab[4] = '{8'h40, 3'b101, 1'b0};
    tab[5] = '{8'h8F, 3'b111, 1'b0};   // SOD enable clear: sod held
    tab[6] = '{8'hCA, 3'b010, 1'b1};

    // ---- reset state ----
    RST = 1; ticks(2); RST = 0;
    check("rst_int_req", int_req, 0);
    check("rst_vec_valid", vec_valid, 0);
    check("rst_int_vec", int_vec, 0);
    check("rst_int_src", int_src, 0);
    check("rst_inta_req", inta_req, 0);
    check("rst_rim", rim_data, 8'h07);
    check("rst_sod", sod, 0);

    // ---- SIM table ----
    for (int i = 0; i < 7; i++) begin
      sim_write(tab[i].data);
      check($sformatf("sim_mask[%0d]", i), rim_data[2:0], tab[i].exp_mask);
      check($sformatf("sim_sod[%0d]", i), sod, tab[i].exp_sod);
    end

    // ---- TRAP with IE=0 ----
    RST = 1; tick(); RST = 0;
    TRAP = 1;
    tick(); check("trap_lat_e0", int_req, 0);
    tick(); check("trap_lat_e1", int_req, 0);
    tick(); check("trap_lat_e2", int_req, 1);
    ack();
    check("trap_vec_valid", vec_valid, 1);
    check("trap_int_vec", int_vec, 16'h0024);
    check("trap_int_src", int_src, 0);
    check("trap_req_in_vec", int_req, 0);
    tick();
    check("trap_vec_pulse", vec_valid, 0);
    check("trap_vec_hold", int_vec, 16'h0024);
    tick(); check("trap_no_rereq", int_req, 0);
    TRAP = 0; ticks(3);

    // ---- EI delay, unmask, 6.5 over 5.5 ----
    ie_set = 1; tick(); ie_set = 0;
    check("ei_pending_ie0", rim_data[3], 0);
    sim_write(8'h08);
    RST55 = 1; RST65 = 1;
    ticks(3); check("ei_no_req_yet", int_req, 0);
    instr_done = 1; tick(); instr_done = 0;
    check("ei_ie_now1", rim_data[3], 1);
    check("ei_req_not_yet", int_req, 0);
    tick(); check("ei_req", int_req, 1);
    ack();
    check("r65_int_vec", int_vec, 16'h0034);
    check("r65_int_src", int_src, 2);
    check("r65_ie_cleared", rim_data[3], 0);
    RST55 = 0; RST65 = 0; ticks(3);

    // ---- RST7.5 latch, mask, SIM clear, coincident edge ----
    enable_ints();
    sim_write(8'h0C);
    check("m75_set", rim_data[2:0], 3'b100);
    RST75 = 1; tick(); RST75 = 0; ticks(4);
    check("r75_latched", rim_data[6], 1);
    check("r75_masked_noreq", int_req, 0);
    sim_write(8'h10);
    check("r75_sim_clear", rim_data[6], 0);
    RST75 = 1; ticks(2);
    sim_write(8'h10);
    check("r75_edge_wins", rim_data[6], 1);
    check("r75_coinc_noreq", int_req, 0);
    sim_write(8'h10);
    check("r75_clear_level", rim_data[6], 0);
    RST75 = 0; ticks(2);

    // ---- INTR with CALL: three INTA cycles ----
    INTR = 1;
    ticks(2); check("intr_req_e1", int_req, 0);
    tick();   check("intr_req_e2", int_req, 1);
    ack(); INTR = 0;
    check("intr_inta1", inta_req, 1);
    check("intr_src", int_src, 4);
    check("intr_no_vec", vec_valid, 0);
    bus_done = 1; op_call = 1;
    tick(); check("intr_inta2", inta_req, 1);
    tick(); check("intr_inta3", inta_req, 1);
    tick(); check("intr_idle", inta_req, 0);
    check("intr_vec_held", int_vec, 16'h0034);
    bus_done = 0;

    // ---- INTR without CALL ----
    enable_ints();
    INTR = 1; ticks(3); check("intr2_req", int_req, 1);
    ack(); INTR = 0;
    check("intr2_inta1", inta_req, 1);
    bus_done = 1; op_call = 0; tick(); bus_done = 0;
    check("intr2_idle", inta_req, 0);

    // ---- TRAP dropped before ack; EI+DI together ----
    TRAP = 1; ticks(3); check("trap2_req", int_req, 1);
    TRAP = 0; ticks(4); check("trap2_dropped", int_req, 0);
    tick(); check("trap2_stays_low", int_req, 0);
    ie_set = 1; ie_clr = 1; tick(); strobes_off();
    instr_done = 1; tick(); instr_done = 0;
    check("ei_di_same", rim_data[3], 0);

    // ---- reset during INTA2 ----
    sim_write(8'h08);
    enable_ints();
    INTR = 1; ticks(3); check("rst_intr_req", int_req, 1);
    ack(); INTR = 0;
    bus_done = 1; op_call = 1; tick();
    check("rst_in_inta2", inta_req, 1);
    RST = 1; tick(); RST = 0;
    check("rst_inta_drop", inta_req, 0);
    check("rst_masks", rim_data[2:0], 3'b111);
    check("rst_req_low", int_req, 0);
    bus_done = 0; tick();
    check("rst_inta_stays", inta_req, 0);
    op_call = 0;

    // ---- randomized vs reference model ----
    RST = 1;
    for (int i = 0; i < 4000; i++) begin
      @(posedge CLK);
      model_edge();
      #1;
      exp_rim = {h[5][1], m_i75, h[2][1], h[3][1], m_ie, m_mask};
      check("rnd_int_req", int_req, m_int_req);
      check("rnd_vec_valid", vec_valid, m_vec_valid);
      check("rnd_int_vec", int_vec, m_vec);
      check("rnd_int_src", int_src, m_src);
      check("rnd_inta_req", inta_req, m_mode >= 2);
      check("rnd_rim", rim_data, exp_rim);
      check("rnd_sod", sod, m_sod);
      RST        = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 11) == 0) TRAP  = ~TRAP;
      if ($urandom_range(0, 11) == 0) RST75 = ~RST75;
      if ($urandom_range(0, 11) == 0) RST65 = ~RST65;
      if ($urandom_range(0, 11) == 0) RST55 = ~RST55;
      if ($urandom_range(0, 11) == 0) INTR  = ~INTR;
      if ($urandom_range(0, 7) == 0)  SID   = ~SID;
      sim_wr     = ($urandom_range(0, 11) == 0);
      sim_data   = 8'($urandom);
      ie_set     = ($urandom_range(0, 5) == 0);
      ie_clr     = ($urandom_range(0, 29) == 0);
      instr_done = ($urandom_range(0, 1) == 0);
      int_ack    = instr_done & ($urandom_range(0, 1) == 0);
      bus_done   = ($urandom_range(0, 2) == 0);
      op_call    = ($urandom_range(0, 1) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/intr_ctrl85.md
INTR_CTRL85 -- requirements
Module: intr_ctrl85

Interface
REQ-001 The block SHALL have parameter VEC_WIDTH, default 16, the width of the vector address output.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset; synchronous, active-high.
REQ-004 TRAP, RST75, RST65, RST55, INTR  input  1 each  asynchronous interrupt pins.
REQ-005 SID  input  1  serial input pin, reported in RIM bit 7.
REQ-006 sim_wr  input  1  one-cycle SIM strobe; sim_data  input  8  accumulator value.
REQ-007 ie_set / ie_clr  input  1 each  EI / DI strobes from the control unit.
REQ-008 instr_done  input  1  one-cycle strobe at each instruction boundary.
REQ-009 int_ack  input  1  core accepts the pending interrupt (valid only with instr_done).
REQ-010 bus_done  input  1  bus unit completed the current INTA cycle; op_call  input  1  the byte fetched in INTA1 is CALL.
REQ-011 int_req  output  1  registered interrupt request to the control unit.
REQ-012 vec_valid  output  1  one-cycle pulse; int_vec  output  VEC_WIDTH  restart address.
REQ-013 inta_req  output  1  bus unit runs an INTA cycle; int_src  output  3  accepted source (0 TRAP, 1 7.5, 2 6.5, 3 5.5, 4 INTR).
REQ-014 rim_data  output  8  RIM value; sod  output  1  serial output latch.

Function
REQ-015 All five interrupt pins and SID SHALL pass through 2-flop synchronizers before use.
REQ-016 TRAP: latch set on synchronized rising edge; the request SHALL require latch=1 AND synchronized level=1; latch cleared on TRAP acceptance.
REQ-017 RST7.5: latch set on synchronized rising edge regardless of mask; cleared by RST7.5 acceptance, by sim_wr with sim_data[4]=1, or by reset; a simultaneous edge and clear SHALL leave the latch set.
REQ-018 RST6.5, RST5.5, INTR: level-sensitive on the synchronized value, no latch.
REQ-019 sim_wr with sim_data[3]=1 SHALL load masks M7.5/M6.5/M5.5 from sim_data[2:0]; sim_data[6]=1 SHALL load sod from sim_data[7]; other bits are ignored.
REQ-020 rim_data SHALL be {SID_sync, I7.5 latch, RST65_sync, RST55_sync, IE, M7.5, M6.5, M5.5}, combinational from registers.
REQ-021 Eligibility: TRAP always; 7.5/6.5/5.5 need IE=1 and mask=0; INTR needs IE=1.
REQ-022 Priority SHALL be TRAP > 7.5 > 6.5 > 5.5 > INTR.
REQ-023 int_req SHALL be registered: high the cycle after any eligible source is seen while FSM=IDLE; low in every other FSM state.
REQ-024 Latency: a pin held high before edge k SHALL raise int_req after edge k+2 (no other blocking condition).
REQ-025 EI: ie_set sets ie_pend; IE becomes 1 on the next instr_done after the EI strobe (one-instruction delay). ie_clr clears IE and ie_pend immediately; ie_clr wins over a simultaneous ie_set.
REQ-026 FSM states: IDLE, VEC, INTA1, INTA2, INTA3.
REQ-027 IDLE -> on int_ack & instr_done & int_req: latch int_src from the highest-priority eligible source; clear IE and ie_pend; go to VEC for TRAP/7.5/6.5/5.5, INTA1 for INTR.
REQ-028 VEC: vec_valid=1 for one cycle with int_vec = 0x0024/0x003C/0x0034/0x002C for TRAP/7.5/6.5/5.5 (zero-extended); -> IDLE.
REQ-029 INTA1/2/3: inta_req=1; advance on bus_done; INTA1 -> INTA2 if op_call else IDLE; INTA2 -> INTA3; INTA3 -> IDLE.
REQ-030 int_ack outside IDLE SHALL be ignored; sources arriving during VEC/INTAx stay pending (latches held, levels re-evaluated on return to IDLE).
REQ-031 int_vec SHALL hold its last value outside VEC; int_src holds until next acceptance.

Reset
REQ-032 On RST: FSM=IDLE, IE=0, ie_pend=0, masks=3'b111, TRAP/7.5 latches=0, synchronizers=0, sod=0, int_req=0, vec_valid=0, inta_req=0, int_vec=0, int_src=0.
REQ-033 RST asserted mid-INTA sequence SHALL drop inta_req on the next edge with no further bus_done response.

Verification
REQ-034 Reset, TRAP rising edge held high -> int_req high 3 edges later despite IE=0; ack -> vec_valid with int_vec=0x0024, int_src=0.
REQ-035 EI, SIM 0x08 (unmask), RST55 and RST65 high -> int_req only after next instr_done; ack -> int_vec=0x0034; IE reads 0 in rim_data.
REQ-036 RST7.5 pulse with M7.5=1 -> rim_data[6]=1, no int_req; SIM 0x10 -> rim_data[6]=0; SIM 0x10 coincident with new edge -> rim_data[6]=1.
REQ-037 INTR with IE=1: ack -> INTA1; bus_done with op_call=1 -> INTA2, INTA3, IDLE after 3 bus_done; with op_call=0 -> IDLE after 1.
REQ-038 TRAP pulse dropped before ack (latch set, level low) -> no int_req; ie_set & ie_clr same cycle -> IE stays 0.
REQ-039 RST during INTA2 -> inta_req=0, masks=3'b111, int_req=0 after that edge.
